// File: rtl/prefetch_queue.sv
// Instruction prefetcher: one outstanding ROM fetch feeding a DEPTH-entry {pc, instr} queue.
// Latency: ROM response pushed at the end of its cycle, visible on out_* the next cycle.
// Backpressure: fetching stalls while queued plus in-flight entries would exceed DEPTH.
module prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     branch_valid,
    input  logic [XLEN-1:0]          branch_target,
    output logic                     rom_req,
    output logic [XLEN-1:0]          rom_address,
    input  logic                     rom_valid,
    input  logic [XLEN-1:0]          rom_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            busy;
    logic            discard;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [AW+1:0]   inflight;
    logic            push;
    logic            pop;

    // Reserve a slot for the outstanding fetch so a push can never hit a full queue.
    assign inflight    = {1'b0, count} + {{(AW+1){1'b0}}, busy};
    assign rom_req     = rst & ~branch_valid & (~busy | rom_valid) & (inflight < (AW+2)'(DEPTH));
    assign rom_address = fetch_pc;
    assign push        = rom_valid & busy & ~discard & ~branch_valid;
    assign out_valid   = (count != '0);
    assign pop         = out_valid & out_ready & ~branch_valid;
    assign out_instr   = instr_mem[rd_ptr];
    assign out_pc      = pc_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            busy     <= 1'b0;
            discard  <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (branch_valid) begin
            fetch_pc <= branch_target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            // A fetch still in flight belongs to the old stream: drop it on arrival.
            if (busy) begin
                if (rom_valid) begin
                    busy    <= 1'b0;
                    discard <= 1'b0;
                end else begin
                    discard <= 1'b1;
                end
            end
        end else begin
            if (rom_req) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + PC_STEP;
                busy     <= 1'b1;
            end else if (busy && rom_valid) begin
                busy <= 1'b0;
            end
            if (busy && rom_valid) begin
                discard <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= rom_data;
        end
    end
endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: ROM model answering addr+0x100, stream-order reference, directed and random phases.
module tb_prefetch_queue;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        rom_req;
    logic [31:0] rom_address;
    logic        rom_valid;
    logic [31:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    prefetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .PC_STEP(32'd1), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .rom_req(rom_req), .rom_address(rom_address),
        .rom_valid(rom_valid), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .count(count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: expected next popped PC, next fetch address, queue occupancy.
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    int          model_count;
    // ROM model state.
    logic        rom_pend;
    logic        rom_stale;
    logic        rv_good;
    logic [31:0] rom_addr_q;
    int          rom_wait;
    int          lat;
    logic        rand_lat;
    logic        s_req;
    logic [31:0] s_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic acc;
        logic popd;
        #2;
        check("count", 64'(count), 64'(model_count));
        check("out_valid", 64'(out_valid), 64'(model_count != 0));
        if (branch_valid) check("req_in_branch", 64'(rom_req), 64'd0);
        if (rom_pend && !rom_valid) check("one_outstanding", 64'(rom_req), 64'd0);
        acc  = rom_valid & rv_good & ~branch_valid;
        popd = (model_count != 0) & out_ready & ~branch_valid;
        if (popd) begin
            check("out_pc", 64'(out_pc), 64'(exp_pc));
            check("out_instr", 64'(out_instr), 64'(32'(exp_pc + 32'h100)));
            exp_pc = exp_pc + 32'd1;
        end
        if (rom_req && !branch_valid) begin
            check("rom_address", 64'(rom_address), 64'(exp_fetch));
            exp_fetch = exp_fetch + 32'd1;
        end
        s_req  = rom_req;
        s_addr = rom_address;
        @(posedge clk);
        #1;
        if (branch_valid) begin
            model_count = 0;
            exp_pc      = branch_target;
            exp_fetch   = branch_target;
        end else begin
            model_count = model_count + int'(acc) - int'(popd);
        end
        if (rom_valid) begin
            rom_pend  = 1'b0;
            rom_stale = 1'b0;
        end else if (branch_valid && rom_pend) begin
            rom_stale = 1'b1;
        end
        if (s_req) begin
            rom_pend   = 1'b1;
            rom_stale  = 1'b0;
            rom_addr_q = s_addr;
            rom_wait   = (rand_lat ? int'($urandom_range(1, 3)) : lat) - 1;
        end
        rom_valid = 1'b0;
        rv_good   = 1'b0;
        if (rom_pend) begin
            if (rom_wait == 0) begin
                rom_valid = 1'b1;
                rom_data  = rom_addr_q + 32'h100;
                rv_good   = ~rom_stale;
            end else begin
                rom_wait--;
            end
        end
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        branch_valid = 1'b0;
        rom_valid    = 1'b0;
        rv_good      = 1'b0;
        rom_pend     = 1'b0;
        rom_stale    = 1'b0;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_rom_req", 64'(rom_req), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b1;
        model_count = 0;
        exp_pc      = RESET_PC;
        exp_fetch   = RESET_PC;
    endtask

    initial begin
        logic found;
        rst = 1'b0; branch_valid = 1'b0; branch_target = '0;
        rom_valid = 1'b0; rom_data = '0; out_ready = 1'b0;
        rom_pend = 1'b0; rom_stale = 1'b0; rv_good = 1'b0; rom_addr_q = '0; rom_wait = 0;
        lat = 1; rand_lat = 1'b0; s_req = 1'b0; s_addr = '0;
        model_count = 0; exp_pc = RESET_PC; exp_fetch = RESET_PC;
        @(posedge clk);
        #1;

        // Fill with a 1-cycle ROM: one instruction per cycle after two cycles.
        out_ready = 1'b1;
        do_reset();
        #1;
        check("first_req", 64'(rom_req), 64'd1);
        check("first_addr", 64'(rom_address), 64'(RESET_PC));
        tick();
        #1;
        check("fill_empty", 64'(out_valid), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_pc", 64'(out_pc), 64'(i));
            check("stream_instr", 64'(out_instr), 64'(32'h100 + i));
            tick();
        end

        // Full queue stalls fetching, then drains in order and resumes at 4.
        out_ready = 1'b0;
        do_reset();
        repeat (8) tick();
        #1;
        check("full_count", 64'(count), 64'd4);
        check("full_no_req", 64'(rom_req), 64'd0);
        check("full_fetch_pc", 64'(rom_address), 64'd4);
        out_ready = 1'b1;
        #1;
        check("drain_head", 64'(out_pc), 64'd0);
        tick();
        #1;
        check("resume_req", 64'(rom_req), 64'd1);
        check("resume_addr", 64'(rom_address), 64'd4);
        check("drain_next", 64'(out_pc), 64'd1);
        repeat (10) tick();

        // Branch while a slow fetch to 5 is in flight: stale response dropped.
        lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_req && s_addr == 32'd5) begin
                found = 1'b1;
                break;
            end
        end
        check("req5_seen", 64'(found), 64'd1);
        branch_valid  = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rom_req) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("br_req_seen", 64'(found), 64'd1);
        check("br_req_addr", 64'(rom_address), 64'h40);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("br_out_seen", 64'(found), 64'd1);
        check("br_out_pc", 64'(out_pc), 64'h40);
        repeat (6) tick();

        // Branch coinciding with a ROM response while two entries are queued.
        lat = 1;
        out_ready = 1'b0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (count == 3'd2) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("cnt2_seen", 64'(found), 64'd1);
        branch_valid  = 1'b1;
        branch_target = 32'h80;
        #1;
        check("br_same_req", 64'(rom_req), 64'd0);
        tick();
        branch_valid = 1'b0;
        #1;
        check("br_same_count", 64'(count), 64'd0);
        check("br_same_req2", 64'(rom_req), 64'd1);
        check("br_same_addr", 64'(rom_address), 64'h80);
        repeat (4) tick();

        // Reset with a busy, partly full queue, then a stray response.
        do_reset();
        repeat (4) tick();
        #1;
        check("pre_rst_count", 64'(count), 64'd3);
        do_reset();
        rom_valid = 1'b1;
        rom_data  = 32'hDEAD;
        rv_good   = 1'b0;
        #1;
        check("post_rst_req", 64'(rom_req), 64'd1);
        check("post_rst_addr", 64'(rom_address), 64'(RESET_PC));
        tick();
        #1;
        check("stray_ignored", 64'(count), 64'd0);
        tick();
        #1;
        check("post_rst_cnt", 64'(count), 64'd1);
        check("post_rst_pc", 64'(out_pc), 64'(RESET_PC));
        check("post_rst_instr", 64'(out_instr), 64'(RESET_PC + 32'h100));

        // PC wrap at the top of the address space.
        out_ready     = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        tick();
        branch_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("wrap_seen", 64'(found), 64'd1);
        check("wrap_pc0", 64'(out_pc), 64'hFFFF_FFFF);
        tick();
        #1;
        check("wrap_valid1", 64'(out_valid), 64'd1);
        check("wrap_pc1", 64'(out_pc), 64'd0);
        check("wrap_instr1", 64'(out_instr), 64'h100);

        // Random traffic: consumer stalls, variable ROM latency, branches, rare resets.
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            out_ready    = ($urandom_range(0, 3) != 0);
            branch_valid = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       branch_target = $urandom;
                1:       branch_target = 32'hFFFF_FFFD;
                default: branch_target = 32'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 499) == 0) do_reset();
            tick();
        end
        branch_valid = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
